// File: rtl/ibex_pmp_chk_arb.sv
// Round-robin arbiter that shares one PMP checker channel among several requesters.
// Optional IBEX_PMP_ARB_CFG_FENCE_EN: hold off grants and result capture during PMP CSR updates.
module ibex_pmp_chk_arb #(
    parameter int NumReq = 3,
    parameter int IdW    = $clog2(NumReq)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  logic [NumReq*34-1:0] req_addr_i,
    input  logic [NumReq*2-1:0]  req_type_i,
    input  logic [NumReq*2-1:0]  req_priv_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    input  logic [NumReq-1:0]    rsp_ready_i,
    output logic                 rsp_err_o,
    output logic [33:0]          pmp_req_addr_o,
    output logic [1:0]           pmp_req_type_o,
    output logic [1:0]           pmp_priv_mode_o,
    input  logic                 pmp_req_err_i,
    input  logic                 pmp_cfg_update_i,
    output logic                 busy_o
);

    localparam logic [1:0] PMP_ACC_READ = 2'b10;
    localparam logic [1:0] PRIV_LVL_U   = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        RESP  = 2'b10
    } state_e;

    state_e           state_q;
    logic [IdW-1:0]   prio_q;
    logic [IdW-1:0]   id_q;
    logic             err_q;
    logic [33:0]      addr_q;
    logic [1:0]       type_q;
    logic [1:0]       priv_q;

    logic [IdW-1:0]   winner;
    logic             found;
    logic             grant_ok;
    logic             sample_ok;

    logic [33:0]      addr_arr [NumReq];
    logic [1:0]       type_arr [NumReq];
    logic [1:0]       priv_arr [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*34 +: 34];
        assign type_arr[g] = req_type_i[g*2 +: 2];
        assign priv_arr[g] = req_priv_i[g*2 +: 2];
    end

`ifdef IBEX_PMP_ARB_CFG_FENCE_EN
    assign grant_ok  = found & ~pmp_cfg_update_i;
    assign sample_ok = ~pmp_cfg_update_i;
`else
    logic unused_cfg_update;
    assign unused_cfg_update = pmp_cfg_update_i;
    assign grant_ok  = found;
    assign sample_ok = 1'b1;
`endif

    // Round-robin pick: first valid requester scanning upward from prio_q with wrap.
    always_comb begin
        logic [IdW:0]   sum;
        logic [IdW-1:0] idx;
        logic           hit;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            sum    = {1'b0, prio_q} + (IdW+1)'(k);
            idx    = (sum >= (IdW+1)'(NumReq)) ? IdW'(sum - (IdW+1)'(NumReq)) : IdW'(sum);
            hit    = ~found & req_valid_i[idx];
            winner = hit ? idx : winner;
            found  = found | hit;
        end
    end

    // One-hot grant, offered only while idle.
    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && grant_ok) begin
            req_ready_o[winner] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // One-hot response valid towards the requester that owns the in-flight check.
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == RESP) begin
            rsp_valid_o[id_q] = 1'b1;
        end else begin
            rsp_valid_o = '0;
        end
    end

    // Arbitration FSM and channel registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= 34'h0;
            type_q  <= PMP_ACC_READ;
            priv_q  <= PRIV_LVL_U;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ok) begin
                        addr_q  <= addr_arr[winner];
                        type_q  <= type_arr[winner];
                        priv_q  <= priv_arr[winner];
                        id_q    <= winner;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (sample_ok) begin
                        err_q   <= pmp_req_err_i;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[id_q]) begin
                        prio_q  <= (id_q == IdW'(NumReq - 1)) ? '0 : id_q + IdW'(1);
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmp_req_addr_o  = addr_q;
    assign pmp_req_type_o  = type_q;
    assign pmp_priv_mode_o = priv_q;
    assign rsp_err_o       = err_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_pmp_chk_arb.sv
// Randomized scoreboard bench for ibex_pmp_chk_arb against a transaction-level arbiter model.
module tb_ibex_pmp_chk_arb;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*34-1:0] req_addr;
    logic [N*2-1:0] req_type, req_priv;
    logic           rsp_err, pmp_err, cfg_upd, busy;
    logic [33:0]    pmp_addr;
    logic [1:0]     pmp_type, pmp_priv;

    ibex_pmp_chk_arb #(.NumReq(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_type_i(req_type), .req_priv_i(req_priv),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err),
        .pmp_req_addr_o(pmp_addr), .pmp_req_type_o(pmp_type), .pmp_priv_mode_o(pmp_priv),
        .pmp_req_err_i(pmp_err), .pmp_cfg_update_i(cfg_upd), .busy_o(busy)
    );

    // Stand-in PMP rule: a fixed region denied below M-mode, plus a write fault pattern.
    function automatic logic chan_rule(logic [33:0] a, logic [1:0] t, logic [1:0] p);
        return ((a[33:30] == 4'h2) && (p != 2'b11)) || ((t == 2'b01) && a[2]);
    endfunction
    assign pmp_err = chan_rule(pmp_addr, pmp_type, pmp_priv);

    typedef struct {
        int   id;
        logic err;
        int   due;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          m_prio = 0;
    int          m_free_cyc = 0;
    int          grant_cyc = 0;
    bit          check_pending = 1'b0;
    bit          post_rst = 1'b0;
    bit          shown = 1'b0;
    logic [33:0] g_addr;
    logic [1:0]  g_type, g_priv;
    logic [N-1:0] acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predictor: expected grant and channel contents at every sample point.
    task automatic predict();
        int           w;
        bit           idle;
        bit           fence_ok;
        logic [N-1:0] exp_ready;
        exp_t         e;
`ifdef IBEX_PMP_ARB_CFG_FENCE_EN
        fence_ok = !cfg_upd;
`else
        fence_ok = 1'b1;
`endif
        if (rst) return;
        if (post_rst) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_pmp_addr", pmp_addr, 0);
            check("rst_pmp_type", pmp_type, 2'b10);
            check("rst_pmp_priv", pmp_priv, 2'b00);
            post_rst = 1'b0;
        end
        idle = (cyc >= m_free_cyc);
        check("busy", busy, !idle);
        if (check_pending && cyc == grant_cyc + 1) begin
            check("chan_addr", pmp_addr, g_addr);
            check("chan_type", pmp_type, g_type);
            check("chan_priv", pmp_priv, g_priv);
        end
        if (check_pending && cyc > grant_cyc && fence_ok && exp_q.size() > 0) begin
            exp_q[exp_q.size()-1].due = cyc + 1;
            check_pending = 1'b0;
        end
        w = -1;
        exp_ready = '0;
        if (idle && fence_ok) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_prio + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        if (w >= 0) begin
            g_addr = req_addr[w*34 +: 34];
            g_type = req_type[w*2 +: 2];
            g_priv = req_priv[w*2 +: 2];
            e.id  = w;
            e.err = chan_rule(g_addr, g_type, g_priv);
            e.due = -1;
            exp_q.push_back(e);
            grant_cyc     = cyc;
            check_pending = 1'b1;
            m_free_cyc    = 1 << 30;
        end
    endtask

    // Monitor: compares presented responses against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_prio        = 0;
            m_free_cyc    = cyc + 1;
            check_pending = 1'b0;
            shown         = 1'b0;
            post_rst      = 1'b1;
        end else if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                logic [N-1:0] oh;
                exp_t e;
                e = exp_q[0];
                oh = '0;
                oh[e.id] = 1'b1;
                if (!shown) begin
                    check("rsp_latency", cyc, e.due);
                    shown = 1'b1;
                end
                check("rsp_valid", rsp_valid, oh);
                check("rsp_err", rsp_err, e.err);
                if (rsp_ready[e.id]) begin
                    void'(exp_q.pop_front());
                    shown      = 1'b0;
                    m_prio     = (e.id + 1) % N;
                    m_free_cyc = cyc + 1;
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due >= 0 && cyc >= exp_q[0].due) begin
            check("rsp_missing", rsp_valid, 1 << exp_q[0].id);
        end
    end

    task automatic step();
        @(negedge clk);
        predict();
        acc = rst ? '0 : (req_valid & req_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(int i);
        int t, p;
        t = $urandom_range(0, 2);
        p = $urandom_range(0, 2);
        req_valid[i] = 1'b1;
        req_addr[i*34 +: 34] = {2'($urandom_range(0, 3)), 32'($urandom)};
        req_type[i*2 +: 2] = 2'(t);
        req_priv[i*2 +: 2] = (p == 2) ? 2'b11 : 2'(p);
    endtask

    task automatic drive_cycle(int pv, int pr, int pc);
        for (int i = 0; i < N; i++) begin
            if (pv == 0) begin
                req_valid[i] = 1'b0;
            end else if (req_valid[i] && !acc[i]) begin
                if ($urandom_range(0, 99) < 2) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 99) < pv) begin
                new_req(i);
            end else begin
                req_valid[i] = 1'b0;
            end
            rsp_ready[i] = ($urandom_range(0, 99) < pr);
        end
        cfg_upd = ($urandom_range(0, 99) < pc);
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_addr = '0;
        req_type = '0;
        req_priv = '0;
        cfg_upd = 1'b0;
        acc = '0;
        #1;
        repeat (3) step();
        rst = 1'b0;

        // single request from requester 1, faulting address
        req_valid = 3'b010;
        req_addr[34 +: 34] = 34'h0_8000_0000;
        req_type[2 +: 2] = 2'b10;
        req_priv[2 +: 2] = 2'b00;
        rsp_ready = 3'b111;
        step();
        repeat (6) drive_cycle(0, 100, 0);

        // all valids held, responses accepted at once
        repeat (15) drive_cycle(100, 100, 0);
        // heavy backpressure and stray ready bits
        repeat (300) drive_cycle(60, 25, 0);

        // reset while a check is in flight
        repeat (8) drive_cycle(0, 100, 0);
        req_valid = 3'b100;
        rsp_ready = '0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (acc[2]) break;
        end
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < N; i++) new_req(i);
        rsp_ready = '1;
        step();
        repeat (6) drive_cycle(100, 100, 0);

        // random traffic with configuration updates
        repeat (2000) drive_cycle(50, 50, 30);

        repeat (15) drive_cycle(0, 100, 0);
        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
